// File: rtl/citrus_fetch_pkg.sv
// Shared types and helpers for the Citrus instruction-fetch front end.
package citrus_fetch_pkg;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {pc, inst} pairs with flush.
// Head entry is presented combinationally from storage.
module fetch_fifo
    import citrus_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;
    fetch_entry_t  mem_q [DEPTH];

    // Next-state pointers and occupancy; flush wins over any same-cycle push/pop.
    always_comb begin
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q < CW'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_queue.sv
// Citrus instruction-fetch front end: single-outstanding fetch FSM feeding a prefetch queue.
// Optional performance counters are built when CITRUS_FETCH_PERF_EN is defined.
module if_fetch_queue
    import citrus_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef CITRUS_FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stalls
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_data_s;
    logic          req_s, redir_s, push_s, pop_s, flush_s;

    // Requests only start from IDLE, so there is never an outstanding slot to add to the count.
    assign req_s   = (state_q == ST_IDLE) && (count_s < CW'(DEPTH)) && !redirect;
    assign redir_s = redirect && (state_q != ST_BOOT);
    assign pop_s   = id_ready && !redir_s;
    assign push_data_s = '{pc: req_pc_q, inst: imem_rdata};

    // Fetch FSM next state, fetch address and queue push/flush control.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (req_s && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    push_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        if (redir_s) begin
            flush_s    = 1'b1;
            fetch_pc_d = align_word(redirect_pc);
        end else begin
            flush_s = 1'b0;
        end
    end

    // FSM and address registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .clrn        (clrn),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (flush_s),
        .count_o     (count_s),
        .head_o      (head_s)
    );

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_q;
    assign id_valid  = (count_s != '0);
    assign id_pc     = head_s.pc;
    assign id_inst   = head_s.inst;

`ifdef CITRUS_FETCH_PERF_EN
    logic [31:0] perf_redir_q, perf_redir_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating event counters, frozen during BOOT.
    always_comb begin
        if (redir_s) begin
            perf_redir_d = sat_inc32(perf_redir_q);
        end else begin
            perf_redir_d = perf_redir_q;
        end
        if (id_ready && !id_valid && (state_q != ST_BOOT)) begin
            perf_stall_d = sat_inc32(perf_stall_q);
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_redir_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_redir_q <= perf_redir_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_redirects = perf_redir_q;
    assign perf_stalls    = perf_stall_q;
`endif

endmodule
